uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, word-length encodings and default
// oversampling constants used by both the receiver and transmitter.
package uart_pkg;

    localparam int unsigned OsrDefault = 16;
    localparam int unsigned SmpDefault = 7;

    localparam logic [1:0] Wls5 = 2'b00;
    localparam logic [1:0] Wls6 = 2'b01;
    localparam logic [1:0] Wls7 = 2'b10;
    localparam logic [1:0] Wls8 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StMark
    } rx_state_t;

    // Index of the final data bit for a given word-length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        logic [2:0] idx;
        idx = 3'd7;
        unique case (wls)
            Wls5: idx = 3'd4;
            Wls6: idx = 3'd5;
            Wls7: idx = 3'd6;
            Wls8: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to the idle
// level 1 so a reset line looks like an idle UART.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with parity, framing
// and break detection, producing one push strobe per received character.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OSR = OsrDefault,
    parameter int unsigned SMP = SmpDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       rx_en,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_data,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       busy
);

    localparam int unsigned   TW      = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [TW-1:0] TickMax = TW'(OSR - 1);
    localparam logic [TW-1:0] TickSmp = TW'(SMP);

    rx_state_t     state_q, state_d;
    logic          rxs;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_q;
    logic [1:0]    wls_q;
    logic          pen_q, eps_q, sp_q;
    logic [7:0]    shift_q;
    logic          par_err_q;
    logic          zero_q;
    logic          sample;
    logic          start_det;
    logic          last_bit;
    logic          exp_par;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign sample    = baud_pulse && (tick_q == TickSmp);
    assign start_det = (state_q == StIdle) && rx_en && !rxs;
    assign last_bit  = (bit_q == last_bit_idx(wls_q));
    // Stick parity forces ~eps; otherwise odd (eps=0) or even (eps=1) over the data.
    assign exp_par   = sp_q ? ~eps_q : (^shift_q ^ ~eps_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != StIdle && !rx_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start_det) state_d = StStart;
                StStart:  if (sample) state_d = rxs ? StIdle : StData;
                StData:   if (sample && last_bit) state_d = pen_q ? StParity : StStop;
                StParity: if (sample) state_d = StStop;
                StStop:   if (sample) state_d = (zero_q && !rxs) ? StMark : StIdle;
                StMark:   if (rxs) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q    <= '0;
            bit_q     <= '0;
            wls_q     <= '0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            zero_q    <= 1'b0;
            rx_data   <= '0;
            push      <= 1'b0;
            pe        <= 1'b0;
            fe        <= 1'b0;
            bi        <= 1'b0;
        end else begin
            push <= 1'b0;
            if (start_det) begin
                tick_q    <= '0;
                bit_q     <= '0;
                shift_q   <= '0;
                par_err_q <= 1'b0;
                zero_q    <= 1'b1;
                wls_q     <= wls;
                pen_q     <= pen;
                eps_q     <= eps;
                sp_q      <= sp;
            end else if (state_q != StIdle) begin
                if (baud_pulse) begin
                    tick_q <= (tick_q == TickMax) ? '0 : tick_q + TW'(1);
                end
                if (sample && rx_en) begin
                    case (state_q)
                        StData: begin
                            shift_q[bit_q] <= rxs;
                            bit_q          <= bit_q + 3'd1;
                            zero_q         <= zero_q & ~rxs;
                        end
                        StParity: begin
                            par_err_q <= (rxs != exp_par);
                            zero_q    <= zero_q & ~rxs;
                        end
                        StStop: begin
                            rx_data <= shift_q;
                            pe      <= par_err_q;
                            fe      <= ~rxs;
                            bi      <= zero_q & ~rxs;
                            push    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of framed characters plus hand-written
// sequences for false start, framing error, break, enable abort and reset.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       rx_en = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic [7:0] rx_data;
    logic       push, pe, fe, bi, busy;

    logic [1:0] div_q = 2'd0;
    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pc0;

    uart_rx #(.OSR(16), .SMP(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_pulse (baud_pulse),
        .rx         (rx),
        .rx_en      (rx_en),
        .wls        (wls),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .rx_data    (rx_data),
        .push       (push),
        .pe         (pe),
        .fe         (fe),
        .bi         (bi),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One baud pulse every 4 clocks.
    always @(posedge clk) begin
        div_q      <= div_q + 2'd1;
        baud_pulse <= (div_q == 2'd3);
    end

    always @(negedge clk) begin
        if (push === 1'b1) push_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pulses(input int n);
        repeat (n) begin
            do @(negedge clk); while (baud_pulse !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_pulses(16);
    endtask

    // Full frame; also checks push lands exactly one clk after the stop-bit sample pulse.
    task automatic send_frame(input string name, input logic [7:0] data, input int nbits,
                              input logic use_par, input logic par_bit, input logic stop_bit);
        int p0;
        p0 = push_cnt;
        wait_pulses(1);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (use_par) send_bit(par_bit);
        rx = stop_bit;
        wait_pulses(8);
        check({name, " push before stop sample"}, 32'(push), 32'd0);
        @(negedge clk);
        check({name, " push after stop sample"}, 32'(push), 32'd1);
        @(negedge clk);
        check({name, " push width"}, 32'(push), 32'd0);
        rx = 1'b1;
        wait_pulses(16);
        check({name, " push count"}, 32'(push_cnt - p0), 32'd1);
    endtask

    typedef struct {
        string      name;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
        logic [7:0] data;
        logic       par_bit;
        logic [7:0] exp_data;
        logic       exp_pe;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{"8N1 A5",        2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{"5O 10 par0",    2'b00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0};
        vecs[2]  = '{"5O 10 par1",    2'b00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 8'h10, 1'b1};
        vecs[3]  = '{"7 stick1 par0", 2'b10, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h55, 1'b0};
        vecs[4]  = '{"7 stick1 par1", 2'b10, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h55, 1'b1};
        vecs[5]  = '{"8E 3C",         2'b11, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[6]  = '{"6E 07",         2'b01, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 8'h07, 1'b0};
        vecs[7]  = '{"8O FF bad",     2'b11, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1};
        vecs[8]  = '{"7N FF",         2'b10, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h7F, 1'b0};
        vecs[9]  = '{"8 stick0 00",   2'b11, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[10] = '{"6O 2A",         2'b01, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 8'h2A, 1'b0};

        repeat (4) @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset push", 32'(push), 32'd0);
        check("reset flags", 32'({pe, fe, bi}), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_pulses(4);
        check("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < NV; i++) begin
            wls = vecs[i].wls;
            pen = vecs[i].pen;
            eps = vecs[i].eps;
            sp  = vecs[i].sp;
            send_frame(vecs[i].name, vecs[i].data, 5 + int'(vecs[i].wls), vecs[i].pen,
                       vecs[i].par_bit, 1'b1);
            check({vecs[i].name, " rx_data"}, 32'(rx_data), 32'(vecs[i].exp_data));
            check({vecs[i].name, " pe"}, 32'(pe), 32'(vecs[i].exp_pe));
            check({vecs[i].name, " fe/bi"}, 32'({fe, bi}), 32'd0);
            check({vecs[i].name, " busy"}, 32'(busy), 32'd0);
        end

        // Framing error: stop bit sampled low on a non-zero character.
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        send_frame("fe 5A", 8'h5A, 8, 1'b0, 1'b0, 1'b0);
        check("fe 5A rx_data", 32'(rx_data), 32'h5A);
        check("fe 5A fe/bi/pe", 32'({fe, bi, pe}), 32'b100);
        check("fe 5A busy", 32'(busy), 32'd0);

        // False start: line low for only 4 pulses.
        pc0 = push_cnt;
        wait_pulses(1);
        rx = 1'b0;
        wait_pulses(4);
        check("false start busy during", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_pulses(16);
        check("false start busy after", 32'(busy), 32'd0);
        check("false start push count", 32'(push_cnt - pc0), 32'd0);

        // Enable dropped mid-frame: abort next clk, outputs hold.
        pc0 = push_cnt;
        wait_pulses(1);
        rx = 1'b0;
        wait_pulses(40);
        check("abort busy before", 32'(busy), 32'd1);
        rx_en = 1'b0;
        @(negedge clk);
        check("abort busy next clk", 32'(busy), 32'd0);
        rx = 1'b1;
        wait_pulses(32);
        rx_en = 1'b1;
        wait_pulses(16);
        check("abort push count", 32'(push_cnt - pc0), 32'd0);
        check("abort rx_data held", 32'(rx_data), 32'h5A);
        check("abort fe held", 32'(fe), 32'd1);

        // Reset during DATA of a 0xFF frame.
        pc0 = push_cnt;
        wait_pulses(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid reset rx_data", 32'(rx_data), 32'h00);
        check("mid reset flags", 32'({push, pe, fe, bi}), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        rst = 1'b1;
        rx = 1'b1;
        wait_pulses(128);
        check("mid reset push count", 32'(push_cnt - pc0), 32'd0);
        send_frame("after reset 81", 8'h81, 8, 1'b0, 1'b0, 1'b1);
        check("after reset 81 rx_data", 32'(rx_data), 32'h81);

        // Break: line low for three frame times, then a clean 0x3C.
        pc0 = push_cnt;
        wait_pulses(1);
        rx = 1'b0;
        wait_pulses(30 * 16);
        check("break push count", 32'(push_cnt - pc0), 32'd1);
        check("break rx_data", 32'(rx_data), 32'h00);
        check("break bi/fe/pe", 32'({bi, fe, pe}), 32'b110);
        check("break busy in mark", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_pulses(16);
        check("break busy released", 32'(busy), 32'd0);
        check("break no extra push", 32'(push_cnt - pc0), 32'd1);
        send_frame("post break 3C", 8'h3C, 8, 1'b0, 1'b0, 1'b1);
        check("post break rx_data", 32'(rx_data), 32'h3C);
        check("post break bi/fe", 32'({bi, fe}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
